sync_fifo: RTL and testbench

Single-clock synchronous FIFO buffering DATA_WIDTH-bit words between a producer (WR/dataIn) and a consumer (RD/dataOut). It reports EMPTY/FULL, almost-empty/almost-full thresholds and an occupancy count. It is a generic building block for rate decoupling inside one clock domain. Read data is registered and appears one cycle after an accepted read.

---
 rtl/sync_fifo.sv | 69 ++++++
 tb/tb_sync_fifo.sv | 126 ++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data, occupancy count and
// threshold flags; define FIFO_ERR_FLAGS_EN to add sticky OVERFLOW/UNDERFLOW.
module sync_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int AF_LEVEL   = FIFO_DEPTH - 2,
   parameter int AE_LEVEL   = 2
) (
   input  logic                          Clk,
   input  logic                          Rst,
   input  logic                          WR,
   input  logic                          RD,
   input  logic [DATA_WIDTH-1:0]         dataIn,
   output logic [DATA_WIDTH-1:0]         dataOut,
   output logic                          EMPTY,
   output logic                          FULL,
   output logic                          ALMOST_FULL,
   output logic                          ALMOST_EMPTY,
   output logic [$clog2(FIFO_DEPTH):0]   COUNT
`ifdef FIFO_ERR_FLAGS_EN
   ,
   output logic                          OVERFLOW,
   output logic                          UNDERFLOW
`endif
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic rd_ok, wr_ok;
   assign EMPTY        = COUNT == '0;
   assign FULL         = COUNT == CW'(FIFO_DEPTH);
   assign ALMOST_FULL  = COUNT >= CW'(AF_LEVEL);
   assign ALMOST_EMPTY = COUNT <= CW'(AE_LEVEL);
   assign rd_ok        = RD & ~EMPTY;
   assign wr_ok        = WR & (~FULL | rd_ok);
   // storage is deliberately left unreset; only pointers define valid contents
   always_ff @(posedge Clk) begin
      if (wr_ok) mem[wr_ptr] <= dataIn;
   end
   // pointers, occupancy and registered read data
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         COUNT   <= '0;
         dataOut <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
         if (rd_ok) begin
            rd_ptr  <= rd_ptr + AW'(1);
            dataOut <= mem[rd_ptr];
         end
         COUNT <= (wr_ok & ~rd_ok) ? COUNT + CW'(1) : (rd_ok & ~wr_ok) ? COUNT - CW'(1) : COUNT;
      end
   end
`ifdef FIFO_ERR_FLAGS_EN
   // sticky error flags: rejected write while full, read attempt while empty
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         OVERFLOW  <= 1'b0;
         UNDERFLOW <= 1'b0;
      end else begin
         if (WR & FULL & ~rd_ok) OVERFLOW <= 1'b1;
         if (RD & EMPTY) UNDERFLOW <= 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: randomized self-checking bench for sync_fifo against a queue model
module tb_sync_fifo;
   localparam int DW = 8;
   localparam int DEPTH = 16;
   logic Clk = 1'b0;
   logic Rst = 1'b0;
   logic WR = 1'b0;
   logic RD = 1'b0;
   logic [DW-1:0] dataIn = '0;
   logic [DW-1:0] dataOut;
   logic EMPTY, FULL, ALMOST_FULL, ALMOST_EMPTY;
   logic [4:0] COUNT;
`ifdef FIFO_ERR_FLAGS_EN
   logic OVERFLOW, UNDERFLOW;
`endif
   int checks = 0;
   int failures = 0;
   logic [DW-1:0] q[$];
   logic [DW-1:0] exp_dout = '0;
   bit exp_ovf = 0;
   bit exp_unf = 0;

   sync_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
      .Clk(Clk), .Rst(Rst), .WR(WR), .RD(RD), .dataIn(dataIn), .dataOut(dataOut),
      .EMPTY(EMPTY), .FULL(FULL), .ALMOST_FULL(ALMOST_FULL), .ALMOST_EMPTY(ALMOST_EMPTY),
      .COUNT(COUNT)
`ifdef FIFO_ERR_FLAGS_EN
      , .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
`endif
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all(input string ctx);
      int n = q.size();
      check({ctx, ":count"}, 32'(COUNT), n);
      check({ctx, ":empty"}, 32'(EMPTY), 32'(n == 0));
      check({ctx, ":full"}, 32'(FULL), 32'(n == DEPTH));
      check({ctx, ":almost_full"}, 32'(ALMOST_FULL), 32'(n >= DEPTH - 2));
      check({ctx, ":almost_empty"}, 32'(ALMOST_EMPTY), 32'(n <= 2));
      check({ctx, ":dout"}, 32'(dataOut), 32'(exp_dout));
`ifdef FIFO_ERR_FLAGS_EN
      check({ctx, ":overflow"}, 32'(OVERFLOW), 32'(exp_ovf));
      check({ctx, ":underflow"}, 32'(UNDERFLOW), 32'(exp_unf));
`endif
   endtask

   task automatic step(input string ctx, input bit wr, input bit rd, input logic [DW-1:0] din);
      bit rd_ok, wr_ok;
      @(negedge Clk);
      WR = wr;
      RD = rd;
      dataIn = din;
      @(posedge Clk);
      rd_ok = rd && q.size() > 0;
      wr_ok = wr && (q.size() < DEPTH || rd_ok);
      if (wr && !wr_ok) exp_ovf = 1;
      if (rd && q.size() == 0) exp_unf = 1;
      if (rd_ok) exp_dout = q.pop_front();
      if (wr_ok) q.push_back(din);
      #1;
      check_all(ctx);
   endtask

   task automatic model_reset();
      q.delete();
      exp_dout = '0;
      exp_ovf = 0;
      exp_unf = 0;
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge Clk);
      #1;
      check_all("reset");
      @(negedge Clk);
      Rst = 1'b1;
      for (int i = 0; i < DEPTH; i++) step("fill", 1, 0, DW'(i));
      step("overflow_wr", 1, 0, 8'hAA);
      step("full_wr_rd", 1, 1, 8'h55);
      for (int i = 0; i < DEPTH; i++) step("drain", 0, 1, 8'h00);
      step("underflow_rd", 0, 1, 8'h00);
      check("hold_last", 32'(dataOut), 32'h55);
      step("empty_wr_rd", 1, 1, 8'h77);
      for (int i = 0; i < 4; i++) step("to5", 1, 0, DW'(8'h30 + i));
      step("wr_rd_at5", 1, 1, 8'h99);
      check("count5", 32'(COUNT), 5);
      for (int b = 0; b < 40; b++) begin
         int len = $urandom_range(1, 8);
         int mode = $urandom_range(0, 2);
         for (int k = 0; k < len; k++) begin
            bit w = (mode == 0) ? ($urandom_range(0, 3) != 0) : (mode == 1) ? ($urandom_range(0, 3) == 0) : 1'($urandom);
            bit r = (mode == 1) ? ($urandom_range(0, 3) != 0) : (mode == 0) ? ($urandom_range(0, 3) == 0) : 1'($urandom);
            step("random", w, r, DW'($urandom));
         end
      end
      while (q.size() > 0) step("rand_drain", 0, 1, 8'h00);
      for (int i = 0; i < 7; i++) step("to7", 1, 0, DW'(8'hC0 + i));
      step("read_one", 0, 1, 8'h00);
      step("back7", 1, 0, 8'hC7);
      check("count7", 32'(COUNT), 7);
      @(negedge Clk);
      WR = 1'b0;
      RD = 1'b0;
      #2;
      Rst = 1'b0;
      #1;
      model_reset();
      check_all("midop_reset");
      @(negedge Clk);
      Rst = 1'b1;
      step("post_reset_wr", 1, 0, 8'h3C);
      step("post_reset_rd", 0, 1, 8'h00);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
